// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default width for the bit-serial adder
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_adder_nbit_full_adder_cell.sv
// full_adder_cell: single combinational 1-bit full adder used by the serial adder
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit: bit-serial N-bit adder, one full-adder cell plus carry flop, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output OVF.
module serial_adder_nbit
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             OVF,
`endif
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state, next_state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CW-1:0] cnt;
    logic carry, s, c;

    full_adder_cell u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (s),
        .cout (c)
    );

    assign busy = state != IDLE;
    assign done = state == DONE;

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next state: accept start only in IDLE, leave SHIFT after the last bit, DONE lasts one cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = start ? SHIFT : IDLE;
            SHIFT:   next_state = (cnt == LAST) ? DONE : SHIFT;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture operands on start, then add and shift one bit per SHIFT cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            SUM   <= '0;
            COUT  <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= CIN;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= c;
            cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
            SUM   <= {s, SUM[WIDTH-1:1]};
            if (cnt == LAST) COUT <= c;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the MSB cell differs from carry out of it
    always_ff @(posedge clk) begin
        if (!rst_n)                            OVF <= 1'b0;
        else if (state == SHIFT && cnt == LAST) OVF <= carry ^ c;
    end
`endif
endmodule
